// File: rtl/char_overlay_engine_pkg.sv
// char_overlay_engine_pkg: shared constants, pixel type and slot field-offset helpers
// for the glyph overlay stage. Image defaults follow the OV5640 capture geometry.
// Latency: n/a (package). Backpressure: n/a.
package char_overlay_engine_pkg;

  // Default active image size of the OV5640 capture path
  localparam int OV5640_IMG_W = 640;
  localparam int OV5640_IMG_H = 480;

  localparam int COORD_W = 10;  // default coordinate / pixel counter width
  localparam int RGB_W   = 24;  // RGB888 pixel width
  localparam int LABEL_W = 4;   // glyph index field per slot

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Bit offsets of slot k inside the flattened label / item buses
  function automatic int label_lsb(input int k);
    return k * LABEL_W;
  endfunction

  function automatic int item_x_lsb(input int k, input int p_w);
    return 2 * k * p_w;
  endfunction

  function automatic int item_y_lsb(input int k, input int p_w);
    return 2 * k * p_w + p_w;
  endfunction

  // Per-channel average with a 9-bit intermediate so the carry is kept
  function automatic rgb_t rgb_avg(input rgb_t a, input rgb_t b);
    rgb_t res;
    res.r = 8'(({1'b0, a.r} + {1'b0, b.r}) >> 1);
    res.g = 8'(({1'b0, a.g} + {1'b0, b.g}) >> 1);
    res.b = 8'(({1'b0, a.b} + {1'b0, b.b}) >> 1);
    return res;
  endfunction

endpackage

// File: rtl/char_overlay_engine_match.sv
// char_slot_match: combinational box test of one pixel position against N_SLOT glyph
// boxes plus lowest-index priority select; outputs hit, glyph index and box-relative x/y.
// Latency: 0 (pure combinational). Backpressure: none.
// Ports: pix_x/pix_y pixel position; slot_en/label/item slot placement (flattened);
//        hit/glyph/rel_x/rel_y winning slot result.
module char_slot_match
  import char_overlay_engine_pkg::*;
#(
  parameter int P_W     = COORD_W,
  parameter int N_SLOT  = 16,
  parameter int GLYPH_W = 32,
  parameter int GLYPH_H = 128,
  parameter int N_GLYPH = 8,
  localparam int GB = $clog2(N_GLYPH),
  localparam int XB = $clog2(GLYPH_W),
  localparam int YB = $clog2(GLYPH_H)
) (
  input  logic [P_W-1:0]            pix_x,
  input  logic [P_W-1:0]            pix_y,
  input  logic [N_SLOT-1:0]         slot_en,
  input  logic [N_SLOT*LABEL_W-1:0] label,
  input  logic [N_SLOT*2*P_W-1:0]   item,
  output logic                      hit,
  output logic [GB-1:0]             glyph,
  output logic [XB-1:0]             rel_x,
  output logic [YB-1:0]             rel_y
);

  logic [LABEL_W-1:0] lbl;
  logic [P_W-1:0]     sx;
  logic [P_W-1:0]     sy;
  logic [P_W:0]       dx;
  logic [P_W:0]       dy;

  // Walk slots from highest to lowest index so the lowest hitting slot is the last write.
  // dx/dy carry one extra bit: a set MSB means the pixel is left of / above the box,
  // which is what clips boxes at the origin side and prevents wrap onto earlier lines.
  always_comb begin
    hit   = 1'b0;
    glyph = '0;
    rel_x = '0;
    rel_y = '0;
    lbl   = '0;
    sx    = '0;
    sy    = '0;
    dx    = '0;
    dy    = '0;
    for (int k = N_SLOT - 1; k >= 0; k--) begin
      lbl = label[label_lsb(k) +: LABEL_W];
      sx  = item[item_x_lsb(k, P_W) +: P_W];
      sy  = item[item_y_lsb(k, P_W) +: P_W];
      dx  = {1'b0, pix_x} - {1'b0, sx};
      dy  = {1'b0, pix_y} - {1'b0, sy};
      if (slot_en[k] && !dx[P_W] && !dy[P_W] &&
          (32'(dx) < GLYPH_W) && (32'(dy) < GLYPH_H) && (32'(lbl) < N_GLYPH)) begin
        hit   = 1'b1;
        glyph = lbl[GB-1:0];
        rel_x = dx[XB-1:0];
        rel_y = dy[YB-1:0];
      end
    end
  end

endmodule

// File: rtl/char_overlay_engine.sv
// char_overlay_engine: overlays glyphs from an external 1-bit ROM onto an RGB888 stream
// at N_SLOT frame-shadowed boxes. Latency 3+ROM_LAT cycles. No backpressure; i_valid
// gaps pass through as o_valid gaps. Define CHAR_OVERLAY_BLEND_EN to average FG with the
// pixel on ink instead of opaque substitution.
// Ports: sys_clk/sys_rst_n; i_sof/i_valid/i_data pixel in; i_slot_en/i_label/i_item slot
//        placement; o_rom_addr/i_rom_data glyph ROM; o_valid/o_data pixel out.
module char_overlay_engine
  import char_overlay_engine_pkg::*;
#(
  parameter int               P_W       = COORD_W,
  parameter int               IMG_W     = OV5640_IMG_W,
  parameter int               IMG_H     = OV5640_IMG_H,
  parameter int               N_SLOT    = 16,
  parameter int               GLYPH_W   = 32,
  parameter int               GLYPH_H   = 128,
  parameter int               N_GLYPH   = 8,
  parameter int               ROM_LAT   = 2,
  parameter logic [RGB_W-1:0] FG_COLOR  = 24'hFF_FF_FF,
  parameter logic             INK_LEVEL = 1'b0,
  localparam int GB = $clog2(N_GLYPH),
  localparam int XB = $clog2(GLYPH_W),
  localparam int YB = $clog2(GLYPH_H),
  localparam int AW = GB + YB + XB
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      i_sof,
  input  logic                      i_valid,
  input  logic [RGB_W-1:0]          i_data,
  input  logic [N_SLOT-1:0]         i_slot_en,
  input  logic [N_SLOT*LABEL_W-1:0] i_label,
  input  logic [N_SLOT*2*P_W-1:0]   i_item,
  output logic [AW-1:0]             o_rom_addr,
  input  logic                      i_rom_data,
  output logic                      o_valid,
  output logic [RGB_W-1:0]          o_data
);

  // ---------------- position counters and placement shadow ----------------
  logic [P_W-1:0]            x_q, x_d, y_q, y_d;
  logic [N_SLOT-1:0]         sh_en_q, sh_en_d;
  logic [N_SLOT*LABEL_W-1:0] sh_label_q, sh_label_d;
  logic [N_SLOT*2*P_W-1:0]   sh_item_q, sh_item_d;

  logic                      frame_start;
  logic [P_W-1:0]            pix_x, pix_y;
  logic [N_SLOT-1:0]         cur_en;
  logic [N_SLOT*LABEL_W-1:0] cur_label;
  logic [N_SLOT*2*P_W-1:0]   cur_item;

  // The SOF pixel itself is forced to (0,0) and already uses the freshly captured placement.
  assign frame_start = i_sof & i_valid;
  assign pix_x       = frame_start ? '0 : x_q;
  assign pix_y       = frame_start ? '0 : y_q;
  assign cur_en      = frame_start ? i_slot_en : sh_en_q;
  assign cur_label   = frame_start ? i_label   : sh_label_q;
  assign cur_item    = frame_start ? i_item    : sh_item_q;

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    sh_en_d    = cur_en;
    sh_label_d = cur_label;
    sh_item_d  = cur_item;
    if (i_valid) begin
      if (pix_x == P_W'(IMG_W - 1)) begin
        x_d = '0;
        y_d = (pix_y == P_W'(IMG_H - 1)) ? '0 : pix_y + P_W'(1);
      end else begin
        x_d = pix_x + P_W'(1);
        y_d = pix_y;
      end
    end
  end

  // ---------------- stage 1: box match ----------------
  logic          m_hit;
  logic [GB-1:0] m_glyph;
  logic [XB-1:0] m_rel_x;
  logic [YB-1:0] m_rel_y;

  char_slot_match #(
    .P_W    (P_W),
    .N_SLOT (N_SLOT),
    .GLYPH_W(GLYPH_W),
    .GLYPH_H(GLYPH_H),
    .N_GLYPH(N_GLYPH)
  ) u_match (
    .pix_x  (pix_x),
    .pix_y  (pix_y),
    .slot_en(cur_en),
    .label  (cur_label),
    .item   (cur_item),
    .hit    (m_hit),
    .glyph  (m_glyph),
    .rel_x  (m_rel_x),
    .rel_y  (m_rel_y)
  );

  logic             s1_vld_q, s1_vld_d, s1_hit_q, s1_hit_d;
  logic [GB-1:0]    s1_glyph_q, s1_glyph_d;
  logic [XB-1:0]    s1_rel_x_q, s1_rel_x_d;
  logic [YB-1:0]    s1_rel_y_q, s1_rel_y_d;
  logic [RGB_W-1:0] s1_dat_q, s1_dat_d;

  // ---------------- stage 2: ROM address ----------------
  logic             s2_vld_q, s2_vld_d, s2_hit_q, s2_hit_d;
  logic [RGB_W-1:0] s2_dat_q, s2_dat_d;
  logic [AW-1:0]    rom_addr_q, rom_addr_d;

  // ---------------- ROM wait: hit/pixel ride alongside the read ----------------
  logic             dly_vld_q [ROM_LAT];
  logic             dly_vld_d [ROM_LAT];
  logic             dly_hit_q [ROM_LAT];
  logic             dly_hit_d [ROM_LAT];
  logic [RGB_W-1:0] dly_dat_q [ROM_LAT];
  logic [RGB_W-1:0] dly_dat_d [ROM_LAT];

  // ---------------- final stage ----------------
  logic             o_valid_q, o_valid_d;
  logic [RGB_W-1:0] o_data_q, o_data_d;
  logic             ink;
  logic [RGB_W-1:0] ink_color;

  assign ink = dly_hit_q[ROM_LAT-1] && (i_rom_data == INK_LEVEL);

`ifdef CHAR_OVERLAY_BLEND_EN
  assign ink_color = rgb_avg(rgb_t'(FG_COLOR), rgb_t'(dly_dat_q[ROM_LAT-1]));
`else
  assign ink_color = FG_COLOR;
`endif

  always_comb begin
    s1_vld_d   = i_valid;
    s1_hit_d   = i_valid & m_hit;
    s1_glyph_d = m_glyph;
    s1_rel_x_d = m_rel_x;
    s1_rel_y_d = m_rel_y;
    s1_dat_d   = i_data;

    s2_vld_d   = s1_vld_q;
    s2_hit_d   = s1_hit_q;
    s2_dat_d   = s1_dat_q;
    rom_addr_d = s1_hit_q ? {s1_glyph_q, s1_rel_y_q, s1_rel_x_q} : '0;

    dly_vld_d[0] = s2_vld_q;
    dly_hit_d[0] = s2_hit_q;
    dly_dat_d[0] = s2_dat_q;
    for (int i = 1; i < ROM_LAT; i++) begin
      dly_vld_d[i] = dly_vld_q[i-1];
      dly_hit_d[i] = dly_hit_q[i-1];
      dly_dat_d[i] = dly_dat_q[i-1];
    end

    o_valid_d = dly_vld_q[ROM_LAT-1];
    o_data_d  = ink ? ink_color : dly_dat_q[ROM_LAT-1];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      sh_en_q    <= '0;
      sh_label_q <= '0;
      sh_item_q  <= '0;
      s1_vld_q   <= 1'b0;
      s1_hit_q   <= 1'b0;
      s1_glyph_q <= '0;
      s1_rel_x_q <= '0;
      s1_rel_y_q <= '0;
      s1_dat_q   <= '0;
      s2_vld_q   <= 1'b0;
      s2_hit_q   <= 1'b0;
      s2_dat_q   <= '0;
      rom_addr_q <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        dly_vld_q[i] <= 1'b0;
        dly_hit_q[i] <= 1'b0;
        dly_dat_q[i] <= '0;
      end
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      sh_en_q    <= sh_en_d;
      sh_label_q <= sh_label_d;
      sh_item_q  <= sh_item_d;
      s1_vld_q   <= s1_vld_d;
      s1_hit_q   <= s1_hit_d;
      s1_glyph_q <= s1_glyph_d;
      s1_rel_x_q <= s1_rel_x_d;
      s1_rel_y_q <= s1_rel_y_d;
      s1_dat_q   <= s1_dat_d;
      s2_vld_q   <= s2_vld_d;
      s2_hit_q   <= s2_hit_d;
      s2_dat_q   <= s2_dat_d;
      rom_addr_q <= rom_addr_d;
      for (int i = 0; i < ROM_LAT; i++) begin
        dly_vld_q[i] <= dly_vld_d[i];
        dly_hit_q[i] <= dly_hit_d[i];
        dly_dat_q[i] <= dly_dat_d[i];
      end
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
    end
  end

  assign o_rom_addr = rom_addr_q;
  assign o_valid    = o_valid_q;
  assign o_data     = o_data_q;

endmodule

// File: tb/tb_char_overlay_engine.sv
// tb_char_overlay_engine: randomized pixel stream against a box-geometry reference model,
// scoreboard queue checked by an independent output monitor.
// Small image/glyph geometry keeps full frames short.
module tb_char_overlay_engine;

  localparam int PW  = 10;
  localparam int IW  = 64;
  localparam int IH  = 48;
  localparam int NS  = 8;
  localparam int GW  = 8;
  localparam int GH  = 16;
  localparam int NG  = 8;
  localparam int L   = 2;
  localparam int AW  = 3 + 4 + 3;
  localparam logic [23:0] FG  = 24'hFF_FF_FF;
  localparam logic        INK = 1'b0;

  logic            sys_clk, sys_rst_n;
  logic            i_sof, i_valid;
  logic [23:0]     i_data;
  logic [NS-1:0]   slot_en_bus;
  logic [NS*4-1:0] label_bus;
  logic [NS*2*PW-1:0] item_bus;
  logic [AW-1:0]   o_rom_addr;
  logic            i_rom_data;
  logic            o_valid;
  logic [23:0]     o_data;

  char_overlay_engine #(
    .P_W(PW), .IMG_W(IW), .IMG_H(IH), .N_SLOT(NS), .GLYPH_W(GW), .GLYPH_H(GH),
    .N_GLYPH(NG), .ROM_LAT(L), .FG_COLOR(FG), .INK_LEVEL(INK)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_sof(i_sof), .i_valid(i_valid),
    .i_data(i_data), .i_slot_en(slot_en_bus), .i_label(label_bus), .i_item(item_bus),
    .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data), .o_valid(o_valid), .o_data(o_data)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ---------------- slot configuration driven to the DUT ----------------
  logic          cfg_en  [NS];
  logic [3:0]    cfg_lbl [NS];
  logic [PW-1:0] cfg_x   [NS];
  logic [PW-1:0] cfg_y   [NS];

  always_comb begin
    slot_en_bus = '0;
    label_bus   = '0;
    item_bus    = '0;
    for (int k = 0; k < NS; k++) begin
      slot_en_bus[k]            = cfg_en[k];
      label_bus[4*k +: 4]       = cfg_lbl[k];
      item_bus[2*k*PW +: PW]    = cfg_x[k];
      item_bus[2*k*PW+PW +: PW] = cfg_y[k];
    end
  end

  // ---------------- glyph ROM model ----------------
  int rom_mode;  // 0: every bit is ink, 1: address-hashed pattern

  function automatic logic rom_bit(input logic [AW-1:0] a, input int mode);
    int v;
    if (mode == 0) return INK;
    v = int'(a) * 37 + 5;
    return logic'((v >> 3) & 1);
  endfunction

  int cyc = 0;
  logic [AW-1:0] hist [L+1];
  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    hist[0] <= o_rom_addr;
    for (int i = 1; i <= L; i++) hist[i] <= hist[i-1];
  end
  always_comb i_rom_data = rom_bit(hist[L-1], rom_mode);

  // ---------------- reference model ----------------
  typedef struct {
    logic [23:0]   dat;
    logic [AW-1:0] addr;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  int mx, my;
  bit sh_en [NS];
  int sh_lbl [NS];
  int sh_x [NS];
  int sh_y [NS];

  function automatic logic [23:0] ink_of(input logic [23:0] px);
`ifdef CHAR_OVERLAY_BLEND_EN
    logic [23:0] r;
    for (int c = 0; c < 3; c++) r[8*c +: 8] = 8'((int'(FG[8*c +: 8]) + int'(px[8*c +: 8])) / 2);
    return r;
`else
    return FG;
`endif
  endfunction

  int n_checks = 0;
  int n_pass   = 0;
  int n_failp  = 0;
  int white_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else begin
      if (n_failp < 25) $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      n_failp++;
    end
  endtask

  task automatic drive(input bit sof, input bit vld);
    exp_t e;
    int hk, rx, ry;
    logic [23:0] px;
    @(posedge sys_clk);
    #1;
    px = 24'($urandom);
    i_sof = sof;
    i_valid = vld;
    i_data = px;
    if (vld) begin
      if (sof) begin
        mx = 0;
        my = 0;
        for (int k = 0; k < NS; k++) begin
          sh_en[k] = cfg_en[k];
          sh_lbl[k] = int'(cfg_lbl[k]);
          sh_x[k] = int'(cfg_x[k]);
          sh_y[k] = int'(cfg_y[k]);
        end
      end
      hk = -1;
      for (int k = 0; k < NS; k++)
        if (hk < 0 && sh_en[k] && sh_lbl[k] < NG &&
            mx >= sh_x[k] && mx < sh_x[k] + GW && my >= sh_y[k] && my < sh_y[k] + GH)
          hk = k;
      e.dat = px;
      e.addr = '0;
      if (hk >= 0) begin
        rx = mx - sh_x[hk];
        ry = my - sh_y[hk];
        e.addr = AW'((sh_lbl[hk] * GH + ry) * GW + rx);
        if (rom_bit(e.addr, rom_mode) == INK) e.dat = ink_of(px);
      end
      e.cyc = cyc;
      sb.push_back(e);
      mx++;
      if (mx == IW) begin
        mx = 0;
        my++;
        if (my == IH) my = 0;
      end
    end
  endtask

  // gap: 0 back-to-back, 1 random idles (with stray idle-cycle SOF), 2 strict 1/0 toggle
  task automatic stream(input int gap, input int n_pix, input bit with_sof,
                        input int chg_at, input int nx, input int ny);
    for (int p = 0; p < n_pix; p++) begin
      if (p == chg_at) begin
        cfg_x[0] = PW'(nx);
        cfg_y[0] = PW'(ny);
      end
      drive(with_sof && p == 0, 1'b1);
      if (gap == 1 && $urandom_range(0, 2) == 0) drive(1'($urandom_range(0, 1)), 1'b0);
      if (gap == 2) drive(1'b0, 1'b0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < L + 8; i++) drive(1'b0, 1'b0);
  endtask

  task automatic clear_cfg();
    for (int k = 0; k < NS; k++) begin
      cfg_en[k] = 1'b0;
      cfg_lbl[k] = 4'd0;
      cfg_x[k] = '0;
      cfg_y[k] = '0;
    end
  endtask

  // ---------------- output monitor ----------------
  exp_t mon_e;
  always @(negedge sys_clk) begin
    if (sys_rst_n && o_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_failp++;
        $display("FAIL spurious_output: o_valid with no pixel pending, o_data %0h", o_data);
      end else begin
        mon_e = sb.pop_front();
        check("o_data", 32'(o_data), 32'(mon_e.dat));
        check("o_rom_addr", 32'(hist[L]), 32'(mon_e.addr));
        check("latency", 32'(cyc - mon_e.cyc), 32'(L + 3));
        if (o_data == FG) white_cnt++;
      end
    end
  end

  initial begin
    clear_cfg();
    rom_mode = 0;
    mx = 0;
    my = 0;
    for (int k = 0; k < NS; k++) begin
      sh_en[k] = 1'b0;
      sh_lbl[k] = 0;
      sh_x[k] = 0;
      sh_y[k] = 0;
    end
    i_sof = 1'b0;
    i_valid = 1'b0;
    i_data = '0;
    sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_o_valid", 32'(o_valid), 32'd0);
    check("reset_o_data", 32'(o_data), 32'd0);
    check("reset_o_rom_addr", 32'(o_rom_addr), 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // A: single slot, all-ink ROM, back-to-back pixels
    cfg_en[0] = 1'b1; cfg_x[0] = 10; cfg_y[0] = 5; cfg_lbl[0] = 4'd3;
    white_cnt = 0;
    stream(0, IW * IH, 1'b1, -1, 0, 0);
    drain();
    check("white_pixel_count", 32'(white_cnt), 32'(GW * GH));

    // B: overlapping slots 2 and 5, patterned ROM, random gaps
    clear_cfg();
    rom_mode = 1;
    cfg_en[2] = 1'b1; cfg_x[2] = 20; cfg_y[2] = 20; cfg_lbl[2] = 4'd1;
    cfg_en[5] = 1'b1; cfg_x[5] = 22; cfg_y[5] = 24; cfg_lbl[5] = 4'd4;
    stream(1, IW * IH, 1'b1, -1, 0, 0);
    drain();

    // C: edge clipping, out-of-range label, disabled slot, toggling valid
    clear_cfg();
    rom_mode = 0;
    cfg_en[1] = 1'b1; cfg_x[1] = 60; cfg_y[1] = 40; cfg_lbl[1] = 4'd2;
    cfg_en[3] = 1'b1; cfg_x[3] = 0;  cfg_y[3] = 0;  cfg_lbl[3] = 4'd9;
    cfg_en[4] = 1'b0; cfg_x[4] = 30; cfg_y[4] = 10; cfg_lbl[4] = 4'd5;
    cfg_en[6] = 1'b1; cfg_x[6] = 58; cfg_y[6] = 0;  cfg_lbl[6] = 4'd7;
    stream(2, IW * IH, 1'b1, -1, 0, 0);
    drain();

    // D: origin moved mid-frame has no effect until the next SOF (frame E)
    clear_cfg();
    rom_mode = 1;
    cfg_en[0] = 1'b1; cfg_x[0] = 10; cfg_y[0] = 5; cfg_lbl[0] = 4'd6;
    stream(0, IW * IH, 1'b1, IW * 20, 30, 30);
    stream(1, IW * IH, 1'b1, -1, 0, 0);
    // short frame, then resync on the next SOF
    stream(0, 1000, 1'b1, -1, 0, 0);
    stream(0, IW * IH, 1'b1, -1, 0, 0);

    // F: reset in the middle of a frame
    cfg_x[0] = 0; cfg_y[0] = 0;
    stream(0, 1500, 1'b1, -1, 0, 0);
    @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    i_valid = 1'b0;
    i_sof = 1'b0;
    #1;
    check("midreset_o_valid", 32'(o_valid), 32'd0);
    check("midreset_o_data", 32'(o_data), 32'd0);
    check("midreset_o_rom_addr", 32'(o_rom_addr), 32'd0);
    sb.delete();
    mx = 0;
    my = 0;
    for (int k = 0; k < NS; k++) sh_en[k] = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    stream(1, 300, 1'b0, -1, 0, 0);
    stream(1, IW * IH, 1'b1, -1, 0, 0);
    drain();

    check("pending_at_end", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
